// File: rtl/serial_addsub_ctrl_pkg.sv
// rtl/serial_addsub_ctrl_pkg.sv - shared types and constants for the serial add/sub controller
package addsub_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/serial_addsub_ctrl_if.sv
// rtl/serial_addsub_ctrl_if.sv - request/result bundle between a requester and the serial add/sub controller
interface serial_addsub_ctrl_if #(
   parameter int N = 4
);

   logic         in_start;
   logic         in_op;
   logic [N-1:0] in_a;
   logic [N-1:0] in_b;
   logic         out_busy;
   logic         out_done;
   logic [N-1:0] out_s;
   logic         out_co;
   logic         out_ovf;

   // Requester side: issues operands, observes status and result.
   modport master (
      output in_start, in_op, in_a, in_b,
      input  out_busy, out_done, out_s, out_co, out_ovf
   );

   // Controller side.
   modport slave (
      input  in_start, in_op, in_a, in_b,
      output out_busy, out_done, out_s, out_co, out_ovf
   );

endinterface

// File: rtl/serial_addsub_ctrl_fa_bit.sv
// rtl/serial_addsub_ctrl_fa_bit.sv - single combinational 1-bit full-adder cell
module fa_bit (
   input  logic in_b,
   input  logic in_a,
   input  logic in_ci,
   output logic out_co,
   output logic out_s
);

   // Sum and carry of one bit column.
   always_comb begin
      out_s  = in_a ^ in_b ^ in_ci;
      out_co = (in_a & in_b) | (in_ci & (in_a ^ in_b));
   end

endmodule

// File: rtl/serial_addsub_ctrl.sv
// rtl/serial_addsub_ctrl.sv - bit-serial N-bit adder/subtractor controller, LSB first
module serial_addsub_ctrl
   import addsub_pkg::*;
#(
   parameter int N     = 4,
   parameter int CNT_W = $clog2(N + 1)
) (
   input  logic                in_clk,
   input  logic                in_rst_n,
   serial_addsub_ctrl_if.slave bus
);

   state_t           state_q, state_d;
   logic [N-1:0]     sh_a_q, sh_a_d;
   logic [N-1:0]     sh_b_q, sh_b_d;
   logic [N-1:0]     s_q, s_d;
   logic             carry_q, carry_d;
   logic             c_msb_in_q, c_msb_in_d;
   logic             co_q, co_d;
   logic             ovf_q, ovf_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic             fa_s;
   logic             fa_co;
   logic             sub_sel;
   logic             last_bit;
   logic             pre_msb_bit;

   // The one shared full-adder cell; the carry flop closes the loop between bits.
   fa_bit u_fa (
      .in_b   (sh_b_q[0]),
      .in_a   (sh_a_q[0]),
      .in_ci  (carry_q),
      .out_co (fa_co),
      .out_s  (fa_s)
   );

   // Decode the operation select and the bit position being processed.
   always_comb begin
      sub_sel = 1'b0;
      case (bus.in_op)
         OP_ADD: sub_sel = 1'b0;
         OP_SUB: sub_sel = 1'b1;
      endcase
      last_bit    = (cnt_q == CNT_W'(N - 1));
      pre_msb_bit = (cnt_q == CNT_W'(N - 2));
   end

   // State register.
   always_ff @(posedge in_clk) begin
      if (!in_rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: start is only looked at in IDLE, DONE always returns to IDLE.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (bus.in_start) state_d = RUN;
         RUN:     if (last_bit)     state_d = DONE;
         DONE:                      state_d = IDLE;
         default:                   state_d = IDLE;
      endcase
   end

   // Status outputs follow the state directly.
   always_comb begin
      bus.out_busy = (state_q != IDLE);
      bus.out_done = (state_q == DONE);
   end

   // Datapath next values: operand load on accept, one bit column per RUN cycle.
   always_comb begin
      sh_a_d     = sh_a_q;
      sh_b_d     = sh_b_q;
      s_d        = s_q;
      carry_d    = carry_q;
      c_msb_in_d = c_msb_in_q;
      co_d       = co_q;
      ovf_d      = ovf_q;
      cnt_d      = cnt_q;
      case (state_q)
         IDLE: begin
            if (bus.in_start) begin
               // Subtract is A + ~B + 1: invert B here and seed the carry with 1.
               sh_a_d     = bus.in_a;
               sh_b_d     = bus.in_b ^ {N{sub_sel}};
               carry_d    = sub_sel;
               cnt_d      = '0;
               c_msb_in_d = 1'b0;
            end
         end
         RUN: begin
            sh_a_d  = {1'b0, sh_a_q[N-1:1]};
            sh_b_d  = {1'b0, sh_b_q[N-1:1]};
            s_d     = {fa_s, s_q[N-1:1]};
            carry_d = fa_co;
            cnt_d   = cnt_q + CNT_W'(1);
            // Carry leaving bit N-2 is the carry into the MSB column.
            if (pre_msb_bit) begin
               c_msb_in_d = fa_co;
            end
            if (last_bit) begin
               co_d  = fa_co;
               ovf_d = c_msb_in_q ^ fa_co;
            end
         end
         default: begin
         end
      endcase
   end

   // Datapath registers, all cleared by reset.
   always_ff @(posedge in_clk) begin
      if (!in_rst_n) begin
         sh_a_q     <= '0;
         sh_b_q     <= '0;
         s_q        <= '0;
         carry_q    <= 1'b0;
         c_msb_in_q <= 1'b0;
         co_q       <= 1'b0;
         ovf_q      <= 1'b0;
         cnt_q      <= '0;
      end else begin
         sh_a_q     <= sh_a_d;
         sh_b_q     <= sh_b_d;
         s_q        <= s_d;
         carry_q    <= carry_d;
         c_msb_in_q <= c_msb_in_d;
         co_q       <= co_d;
         ovf_q      <= ovf_d;
         cnt_q      <= cnt_d;
      end
   end

   assign bus.out_s   = s_q;
   assign bus.out_co  = co_q;
   assign bus.out_ovf = ovf_q;

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// tb/tb_serial_addsub_ctrl.sv - self-checking bench for serial_addsub_ctrl
module tb_serial_addsub_ctrl;
   import addsub_pkg::*;

   localparam int N = 4;

   logic in_clk;
   logic in_rst_n;
   int   checks;
   int   errors;

   serial_addsub_ctrl_if #(.N(N)) bus_if ();

   serial_addsub_ctrl #(.N(N)) dut (
      .in_clk   (in_clk),
      .in_rst_n (in_rst_n),
      .bus      (bus_if)
   );

   always #5 in_clk = ~in_clk;

   typedef struct {
      logic         op;
      logic [N-1:0] a;
      logic [N-1:0] b;
      bit           poke;
      logic [N-1:0] s;
      logic         co;
      logic         ovf;
   } vec_t;

   vec_t vecs [10];

   task automatic tick();
      @(posedge in_clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // Reference: plain integer arithmetic on the operand values.
   function automatic void model(input logic op, input logic [N-1:0] a, input logic [N-1:0] b,
                                 output logic [N-1:0] s, output logic co, output logic ovf);
      int ua, ub, sa, sb, raw, exact;
      ua = int'(a);
      ub = int'(b);
      sa = (ua >= 2 ** (N - 1)) ? ua - 2 ** N : ua;
      sb = (ub >= 2 ** (N - 1)) ? ub - 2 ** N : ub;
      if (op == OP_SUB) begin
         raw   = ua - ub;
         exact = sa - sb;
         co    = (ua >= ub);
      end else begin
         raw   = ua + ub;
         exact = sa + sb;
         co    = (raw >= 2 ** N);
      end
      s   = N'(raw);
      ovf = (exact > 2 ** (N - 1) - 1) || (exact < -(2 ** (N - 1)));
   endfunction

   // Issue one operation and follow it for N+1 edges after the accepting edge.
   task automatic run_op(input logic op, input logic [N-1:0] a, input logic [N-1:0] b, input bit poke,
                         output logic [N-1:0] s, output logic co, output logic ovf,
                         output int n_done, output int lat, output logic busy0, output logic busy_end);
      bus_if.in_start = 1'b1;
      bus_if.in_op    = op;
      bus_if.in_a     = a;
      bus_if.in_b     = b;
      tick();
      bus_if.in_start = 1'b0;
      bus_if.in_op    = 1'($urandom);
      bus_if.in_a     = N'($urandom);
      bus_if.in_b     = N'($urandom);
      busy0  = bus_if.out_busy;
      n_done = 0;
      lat    = -1;
      s      = 'x;
      co     = 1'bx;
      ovf    = 1'bx;
      for (int j = 1; j <= N + 1; j++) begin
         if (poke && j < N) bus_if.in_start = 1'($urandom_range(0, 1));
         tick();
         bus_if.in_start = 1'b0;
         if (bus_if.out_done) begin
            n_done++;
            lat = j;
            s   = bus_if.out_s;
            co  = bus_if.out_co;
            ovf = bus_if.out_ovf;
         end
      end
      busy_end = bus_if.out_busy;
   endtask

   initial begin
      logic [N-1:0] s, es;
      logic         co, ovf, eco, eovf, busy0, busy_end;
      int           n_done, lat, rst_dones;

      checks = 0;
      errors = 0;
      in_clk = 1'b0;
      in_rst_n = 1'b0;
      bus_if.in_start = 1'b0;
      bus_if.in_op    = 1'b0;
      bus_if.in_a     = '0;
      bus_if.in_b     = '0;

      vecs[0] = '{OP_ADD, 4'd3,  4'd5, 1'b0, 4'b1000, 1'b0, 1'b1};
      vecs[1] = '{OP_SUB, 4'd7,  4'd2, 1'b0, 4'b0101, 1'b1, 1'b0};
      vecs[2] = '{OP_SUB, 4'd2,  4'd7, 1'b0, 4'b1011, 1'b0, 1'b0};
      vecs[3] = '{OP_ADD, 4'd15, 4'd1, 1'b0, 4'b0000, 1'b1, 1'b0};
      vecs[4] = '{OP_ADD, 4'd4,  4'd0, 1'b1, 4'b0100, 1'b0, 1'b0};
      vecs[5] = '{OP_SUB, 4'd6,  4'd6, 1'b1, 4'b0000, 1'b1, 1'b0};
      vecs[6] = '{OP_ADD, 4'd7,  4'd1, 1'b0, 4'b1000, 1'b0, 1'b1};
      vecs[7] = '{OP_SUB, 4'd8,  4'd1, 1'b0, 4'b0111, 1'b1, 1'b1};
      vecs[8] = '{OP_ADD, 4'd1,  4'd3, 1'b0, 4'b0100, 1'b0, 1'b0};
      vecs[9] = '{OP_SUB, 4'd0,  4'd0, 1'b0, 4'b0000, 1'b1, 1'b0};

      tick();
      tick();
      chk("reset busy", 32'(bus_if.out_busy), 32'(0));
      chk("reset done", 32'(bus_if.out_done), 32'(0));
      chk("reset s",    32'(bus_if.out_s),    32'(0));
      chk("reset co",   32'(bus_if.out_co),   32'(0));
      chk("reset ovf",  32'(bus_if.out_ovf),  32'(0));
      in_rst_n = 1'b1;
      tick();

      // Directed table, issued back to back.
      for (int i = 0; i < 10; i++) begin
         run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].poke, s, co, ovf, n_done, lat, busy0, busy_end);
         chk($sformatf("vec%0d s", i),        32'(s),        32'(vecs[i].s));
         chk($sformatf("vec%0d co", i),       32'(co),       32'(vecs[i].co));
         chk($sformatf("vec%0d ovf", i),      32'(ovf),      32'(vecs[i].ovf));
         chk($sformatf("vec%0d dones", i),    32'(n_done),   32'(1));
         chk($sformatf("vec%0d latency", i),  32'(lat),      32'(N));
         chk($sformatf("vec%0d busy0", i),    32'(busy0),    32'(1));
         chk($sformatf("vec%0d busy_end", i), 32'(busy_end), 32'(0));
         chk($sformatf("vec%0d s_hold", i),   32'(bus_if.out_s), 32'(vecs[i].s));
      end

      // Reset in the middle of 5+6 after two bits.
      rst_dones = 0;
      bus_if.in_start = 1'b1;
      bus_if.in_op    = OP_ADD;
      bus_if.in_a     = 4'd5;
      bus_if.in_b     = 4'd6;
      tick();
      bus_if.in_start = 1'b0;
      for (int j = 0; j < 2; j++) begin
         tick();
         if (bus_if.out_done) rst_dones++;
      end
      chk("partial s", 32'(bus_if.out_s), 32'(4'b1100));
      in_rst_n = 1'b0;
      tick();
      if (bus_if.out_done) rst_dones++;
      chk("abort busy", 32'(bus_if.out_busy), 32'(0));
      chk("abort done", 32'(bus_if.out_done), 32'(0));
      chk("abort s",    32'(bus_if.out_s),    32'(0));
      chk("abort co",   32'(bus_if.out_co),   32'(0));
      chk("abort ovf",  32'(bus_if.out_ovf),  32'(0));
      in_rst_n = 1'b1;
      tick();
      if (bus_if.out_done) rst_dones++;
      chk("abort no done", 32'(rst_dones), 32'(0));
      chk("abort idle", 32'(bus_if.out_busy), 32'(0));
      run_op(OP_ADD, 4'd1, 4'd1, 1'b0, s, co, ovf, n_done, lat, busy0, busy_end);
      chk("post-abort s",     32'(s),      32'(4'b0010));
      chk("post-abort co",    32'(co),     32'(0));
      chk("post-abort ovf",   32'(ovf),    32'(0));
      chk("post-abort dones", 32'(n_done), 32'(1));

      // Randomized operations against the arithmetic model.
      for (int i = 0; i < 150; i++) begin
         logic         op;
         logic [N-1:0] a, b;
         op = 1'($urandom);
         a  = N'($urandom);
         b  = N'($urandom);
         model(op, a, b, es, eco, eovf);
         run_op(op, a, b, 1'($urandom), s, co, ovf, n_done, lat, busy0, busy_end);
         chk($sformatf("rnd%0d s", i),     32'(s),      32'(es));
         chk($sformatf("rnd%0d co", i),    32'(co),     32'(eco));
         chk($sformatf("rnd%0d ovf", i),   32'(ovf),    32'(eovf));
         chk($sformatf("rnd%0d dones", i), 32'(n_done), 32'(1));
         for (int k = 0; k < int'($urandom_range(0, 2)); k++) tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
